// File: rtl/itcm_autoload_ahb_master.sv
// ---------------------------------------------------------------------------
// itcm_autoload_ahb_master
//
// Serves word read requests from the ITCM auto-loader over AHB-Lite. Each
// accepted request becomes one single-word read. Address phases are
// pipelined against data phases. Returned words are delivered in request
// order with a one-cycle valid strobe. Session completion, beat count and a
// sticky error flag are reported alongside.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   itcm_auto_load           loader session active / request valid
//   itcm_auto_load_addr      word address of the requested beat
//   IAHB_ready               request accepted this cycle (combinational)
//   IAHB_read_data(_valid)   returned word and its one-cycle strobe
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT   AHB-Lite master address phase
//   HREADY/HRDATA/HRESP      AHB-Lite slave response
//   load_done                pulse when a session ends without error
//   load_error(_addr)        sticky error flag and address of failing beat
//   load_beats               words returned this session (saturating)
// ---------------------------------------------------------------------------
module itcm_autoload_ahb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  itcm_auto_load,
    input  logic [ADDR_WIDTH-1:0] itcm_auto_load_addr,
    output logic                  IAHB_ready,
    output logic [DATA_WIDTH-1:0] IAHB_read_data,
    output logic                  IAHB_read_data_valid,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HRESP,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH-1:0] load_error_addr,
    output logic [CNT_WIDTH-1:0]  load_beats
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_ERR
    } state_t;

    state_t                state;
    logic                  dphase;       // a data phase is outstanding
    logic [ADDR_WIDTH-1:0] dphase_addr;  // address of the outstanding data phase

    logic addr_done;
    logic data_done;
    logic err_first;
    logic handshake;
    logic seq_ok;

    assign HWRITE = 1'b0;
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b001;
    assign HPROT  = 4'b0010;

    assign addr_done = HTRANS[1] && HREADY;
    assign data_done = dphase && HREADY;
    // First cycle of the two-cycle ERROR response; the only point where a
    // stalled address phase may legally be withdrawn.
    assign err_first = dphase && HRESP && !HREADY;

    // NOTE: ready depends combinationally on HREADY so a new address can be
    // accepted in the same cycle the previous address phase completes,
    // which is what sustains one word per cycle.
    assign IAHB_ready = itcm_auto_load && (state == ST_RUN)
                        && ((HTRANS == HTRANS_IDLE) || HREADY)
                        && !(dphase && HRESP);
    assign handshake  = itcm_auto_load && IAHB_ready;

    // Continue the INCR burst only when back-to-back, contiguous, and not
    // starting a new 1KB region.
    assign seq_ok = addr_done
                    && (itcm_auto_load_addr == HADDR + ADDR_WIDTH'(4))
                    && (itcm_auto_load_addr[9:0] != 10'd0);

    // NOTE: all state here is updated with non-blocking assignments so every
    // decision in a cycle sees the pre-edge values of HTRANS, dphase, state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= ST_IDLE;
            dphase               <= 1'b0;
            dphase_addr          <= '0;
            HADDR                <= '0;
            HTRANS               <= HTRANS_IDLE;
            IAHB_read_data       <= '0;
            IAHB_read_data_valid <= 1'b0;
            load_done            <= 1'b0;
            load_error           <= 1'b0;
            load_error_addr      <= '0;
            load_beats           <= '0;
        end else begin
            IAHB_read_data_valid <= 1'b0;
            load_done            <= 1'b0;

            if (err_first) begin
                HTRANS          <= HTRANS_IDLE;
                load_error      <= 1'b1;
                load_error_addr <= dphase_addr;
                state           <= ST_ERR;
            end else begin
                // Address phase pipeline
                if (handshake) begin
                    HADDR  <= itcm_auto_load_addr;
                    HTRANS <= seq_ok ? HTRANS_SEQ : HTRANS_NONSEQ;
                end else if (addr_done) begin
                    HTRANS <= HTRANS_IDLE;
                end

                // Data phase tracking; a completing address phase always
                // opens the next data phase, even if one closes this cycle.
                if (addr_done) begin
                    dphase      <= 1'b1;
                    dphase_addr <= HADDR;
                end else if (data_done) begin
                    dphase <= 1'b0;
                end

                if (data_done && !HRESP) begin
                    IAHB_read_data       <= HRDATA;
                    IAHB_read_data_valid <= 1'b1;
                    if (load_beats != '1) begin
                        load_beats <= load_beats + CNT_WIDTH'(1);
                    end
                end

                unique case (state)
                    ST_IDLE: begin
                        if (itcm_auto_load) begin
                            state      <= ST_RUN;
                            load_beats <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (!itcm_auto_load) begin
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        // Nothing in flight: the last valid has already been
                        // issued, so done follows it.
                        if ((HTRANS == HTRANS_IDLE) && !dphase) begin
                            state     <= ST_IDLE;
                            load_done <= 1'b1;
                        end
                    end
                    ST_ERR: begin
                        if (!itcm_auto_load && !dphase) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_itcm_autoload_ahb_master.sv
// ---------------------------------------------------------------------------
// tb_itcm_autoload_ahb_master
//
// Directed sessions with randomized slave wait states, random read data and
// random address streams. A behavioural AHB slave (memory contents are a
// fixed function of the address) answers the DUT; the expected read stream
// is the ordered list of requested addresses, truncated at an erroring beat.
// ---------------------------------------------------------------------------
module tb_itcm_autoload_ahb_master;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        itcm_auto_load;
    logic [31:0] itcm_auto_load_addr;
    logic        IAHB_ready;
    logic [31:0] IAHB_read_data;
    logic        IAHB_read_data_valid;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        load_done;
    logic        load_error;
    logic [31:0] load_error_addr;
    logic [15:0] load_beats;

    itcm_autoload_ahb_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .CNT_WIDTH (16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .itcm_auto_load      (itcm_auto_load),
        .itcm_auto_load_addr (itcm_auto_load_addr),
        .IAHB_ready          (IAHB_ready),
        .IAHB_read_data      (IAHB_read_data),
        .IAHB_read_data_valid(IAHB_read_data_valid),
        .HADDR               (HADDR),
        .HTRANS              (HTRANS),
        .HWRITE              (HWRITE),
        .HSIZE               (HSIZE),
        .HBURST              (HBURST),
        .HPROT               (HPROT),
        .HREADY              (HREADY),
        .HRDATA              (HRDATA),
        .HRESP               (HRESP),
        .load_done           (load_done),
        .load_error          (load_error),
        .load_error_addr     (load_error_addr),
        .load_beats          (load_beats)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Session configuration
    logic [31:0] req_q[$];   // addresses the loader will request, in order
    logic [31:0] exp_q[$];   // addresses whose words must come back, in order
    int          w_min;
    int          w_max;
    bit          err_en;
    logic [31:0] err_addr;

    // Behavioural slave state
    bit          dp_active;
    bit          dp_err;
    bit          dp_err2;
    int          dp_wait;
    logic [31:0] dp_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_clear();
        dp_active = 1'b0;
        dp_err    = 1'b0;
        dp_err2   = 1'b0;
        dp_wait   = 0;
        dp_addr   = '0;
    endtask

    task automatic fill_linear(input logic [31:0] base, input int n);
        req_q.delete();
        for (int i = 0; i < n; i++) req_q.push_back(base + 32'(4 * i));
    endtask

    task automatic fill_random(input int n);
        logic [31:0] a;
        req_q.delete();
        a = 32'($urandom_range(0, 1023)) << 2;
        for (int i = 0; i < n; i++) begin
            req_q.push_back(a);
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1023)) << 2;
            else                           a = a + 32'd4;
        end
    endtask

    task automatic check_reset_outputs(input string ph);
        check({ph, "_htrans"},  HTRANS, T_IDLE);
        check({ph, "_haddr"},   HADDR, 0);
        check({ph, "_valid"},   IAHB_read_data_valid, 0);
        check({ph, "_rdata"},   IAHB_read_data, 0);
        check({ph, "_ready"},   IAHB_ready, 0);
        check({ph, "_done"},    load_done, 0);
        check({ph, "_err"},     load_error, 0);
        check({ph, "_erraddr"}, load_error_addr, 0);
        check({ph, "_beats"},   load_beats, 0);
    endtask

    // One load session. exp_nonseq < 0 skips the NONSEQ count check;
    // reset_at > 0 asserts rst in that cycle and ends the session there.
    task automatic run_session(input bit chk_latency, input int exp_nonseq,
                               input int reset_at, input bit exp_err_flag);
        int          idx, n, cyc, first_hs, first_v, done_cnt, nonseq, valids;
        int          err_cyc, tail, exp_total;
        bit          prev_hs, prev_hr, prev_stall, finished, ld;
        logic [31:0] prev_hs_addr, prev_ha, a;
        logic [1:0]  prev_ht, exp_ht;

        idx = 0; n = req_q.size(); cyc = 0; first_hs = -1; first_v = -1;
        done_cnt = 0; nonseq = 0; valids = 0; err_cyc = -1; tail = 0;
        prev_hs = 0; prev_hr = 1; prev_stall = 0; finished = 0;
        prev_hs_addr = '0; prev_ha = '0; prev_ht = T_IDLE;

        exp_q.delete();
        foreach (req_q[i]) begin
            if (err_en && req_q[i] == err_addr) break;
            exp_q.push_back(req_q[i]);
        end
        exp_total = exp_q.size();
        slave_clear();

        while (!finished && cyc < 600) begin
            // Loader: keep requesting briefly after an error to show it stalls
            ld = (idx < n) && (err_cyc < 0 || cyc - err_cyc < 4);
            itcm_auto_load      = ld;
            itcm_auto_load_addr = ld ? req_q[idx] : $urandom;

            // Slave response for this cycle
            if (dp_active && dp_wait > 0) begin
                HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom;
            end else if (dp_active && dp_err && !dp_err2) begin
                HREADY = 1'b0; HRESP = 1'b1; HRDATA = $urandom; err_cyc = cyc;
            end else if (dp_active && dp_err) begin
                HREADY = 1'b1; HRESP = 1'b1; HRDATA = $urandom;
            end else if (dp_active) begin
                HREADY = 1'b1; HRESP = 1'b0; HRDATA = mem_word(dp_addr);
            end else begin
                HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
            end
            #1;

            // Address-phase protocol
            if (prev_hs) begin
                check("haddr_issue", HADDR, prev_hs_addr);
                exp_ht = (prev_ht != T_IDLE && prev_hr && prev_hs_addr == prev_ha + 32'd4
                          && prev_hs_addr[9:0] != 10'd0) ? T_SEQ : T_NONSEQ;
                check("htrans_issue", HTRANS, exp_ht);
                if (HTRANS == T_NONSEQ) nonseq++;
            end else if (err_cyc >= 0 && err_cyc == cyc - 1) begin
                check("htrans_cancel", HTRANS, T_IDLE);
                check("err_flag", load_error, 1);
                check("err_addr", load_error_addr, err_addr);
            end else if (prev_stall) begin
                check("haddr_hold", HADDR, prev_ha);
                check("htrans_hold", HTRANS, prev_ht);
            end else if (prev_ht != T_IDLE && prev_hr) begin
                check("htrans_to_idle", HTRANS, T_IDLE);
            end
            if (HTRANS != T_IDLE && !HREADY) check("ready_in_wait", IAHB_ready, 0);
            if (err_cyc >= 0 && ld) check("ready_after_err", IAHB_ready, 0);

            // Read-data stream
            if (IAHB_read_data_valid) begin
                valids++;
                if (first_v < 0) first_v = cyc;
                if (exp_q.size() == 0) check("extra_valid", valids, exp_total);
                else begin
                    a = exp_q.pop_front();
                    check("rdata", IAHB_read_data, mem_word(a));
                end
            end
            if (load_done) begin
                done_cnt++;
                check("done_after_last_valid", exp_q.size(), 0);
            end

            if (reset_at > 0 && cyc == reset_at) begin
                rst = 1'b1; itcm_auto_load = 1'b0;
                HREADY = 1'b1; HRESP = 1'b0;
                #1;
                check_reset_outputs("midrst");
                slave_clear();
                @(negedge clk);
                #1;
                check("midrst_no_valid", IAHB_read_data_valid, 0);
                rst = 1'b0;
                return;
            end

            // Loader handshake
            if (ld && IAHB_ready) begin
                if (first_hs < 0) begin
                    first_hs = cyc;
                    check("beats_cleared", load_beats, 0);
                end
                prev_hs      = 1'b1;
                prev_hs_addr = req_q[idx];
                idx++;
            end else begin
                prev_hs = 1'b0;
            end

            // Slave advances: finish current data phase, then open a new one
            if (dp_active) begin
                if (dp_wait > 0)               dp_wait--;
                else if (dp_err && !dp_err2)   dp_err2 = 1'b1;
                else                           dp_active = 1'b0;
            end
            if (HTRANS != T_IDLE && HREADY) begin
                dp_active = 1'b1;
                dp_addr   = HADDR;
                dp_wait   = $urandom_range(w_max, w_min);
                dp_err    = err_en && (HADDR == err_addr);
                dp_err2   = 1'b0;
            end

            prev_ht    = HTRANS;
            prev_ha    = HADDR;
            prev_hr    = HREADY;
            prev_stall = (HTRANS != T_IDLE) && !HREADY;

            if (!ld && (done_cnt > 0 || err_cyc >= 0)) tail++;
            if (tail >= 8) finished = 1'b1;
            cyc++;
            @(negedge clk);
        end

        check("session_timeout", finished, 1);
        check("missing_valids", exp_q.size(), 0);
        check("valid_count", valids, exp_total);
        check("load_beats", load_beats, exp_total);
        check("done_pulses", done_cnt, err_en ? 0 : 1);
        check("error_sticky", load_error, exp_err_flag);
        check("end_htrans_idle", HTRANS, T_IDLE);
        if (chk_latency) check("first_latency", first_v - first_hs, 3);
        if (exp_nonseq >= 0) check("nonseq_count", nonseq, exp_nonseq);
    endtask

    initial begin
        rst                 = 1'b1;
        itcm_auto_load      = 1'b0;
        itcm_auto_load_addr = '0;
        HREADY              = 1'b1;
        HRESP               = 1'b0;
        HRDATA              = '0;
        err_en              = 1'b0;
        err_addr            = '0;
        w_min               = 0;
        w_max               = 0;
        slave_clear();
        #1;
        check_reset_outputs("reset");
        check("reset_hwrite", HWRITE, 0);
        check("reset_hsize",  HSIZE, 3'b010);
        check("reset_hburst", HBURST, 3'b001);
        check("reset_hprot",  HPROT, 4'b0010);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait 16-word burst from 0
        fill_linear(32'h0000_0000, 16); w_min = 0; w_max = 0;
        run_session(1'b1, 1, 0, 1'b0);

        // Two wait states on every beat
        fill_linear(32'h0000_0100, 8); w_min = 2; w_max = 2;
        run_session(1'b0, 1, 0, 1'b0);

        // Burst across the 1KB boundary with sporadic waits
        fill_linear(32'h0000_03F0, 8); w_min = 0; w_max = 1;
        run_session(1'b0, 2, 0, 1'b0);

        // ERROR response on the beat at 0x10
        fill_linear(32'h0000_0000, 16); w_min = 0; w_max = 0;
        err_en = 1'b1; err_addr = 32'h0000_0010;
        run_session(1'b0, -1, 0, 1'b1);
        err_en = 1'b0;

        // Random address streams and waits; error flag stays set
        for (int s = 0; s < 4; s++) begin
            fill_random(int'($urandom_range(5, 20)));
            w_min = 0; w_max = 3;
            run_session(1'b0, -1, 0, 1'b1);
        end

        // Reset in the middle of a burst, then a fresh session
        fill_linear(32'h0000_0000, 16); w_min = 0; w_max = 1;
        run_session(1'b0, -1, 8, 1'b0);
        @(negedge clk);
        fill_linear(32'h0000_0200, 8); w_min = 0; w_max = 0;
        run_session(1'b1, 1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
